// File: rtl/scan_pkg.sv
// scan_pkg: frame state encoding and chain-length helper shared by the scan frame sequencer.
package scan_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT, DONE} scan_state_t;
    function automatic int chain_len(input int num_designs, input int num_ios);
        return num_designs * num_ios;
    endfunction
endpackage

// File: rtl/scan_clk_phase.sv
// scan_clk_phase: half-period counter that splits each bit slot into a low and a high half.
module scan_clk_phase #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic phase,
    output logic phase_nxt,
    output logic slot_start,
    output logic rise,
    output logic sample,
    output logic slot_end
);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic phase_q, phase_d, wrap;
    always_comb begin
        wrap = cnt_q == LAST;
        cnt_d = en && !wrap ? cnt_q + CW'(1) : '0;
        phase_d = en && (wrap ? !phase_q : phase_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            phase_q <= phase_d;
        end
    end
    assign phase = phase_q;
    assign phase_nxt = phase_d;
    assign slot_start = en && !phase_q && cnt_q == '0;
    assign rise = en && phase_q && cnt_q == '0;
    assign sample = en && phase_q && wrap;
    assign slot_end = sample;
endmodule

// File: rtl/scan_frame_sequencer.sv
// scan_frame_sequencer: counted shift-in / latch / capture / shift-out frame engine for the design scan chain.
module scan_frame_sequencer
    import scan_pkg::*;
#(
    parameter int NUM_DESIGNS = 250,
    parameter int NUM_IOS = 8,
    parameter int CLK_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [8:0]         active_select,
    input  logic [NUM_IOS-1:0] inputs,
    output logic [NUM_IOS-1:0] outputs,
    output logic               ready,
    output logic               busy,
    output logic               scan_clk_out,
    output logic               scan_data_out,
    output logic               scan_select,
    output logic               scan_latch_en,
    input  logic               scan_data_in
);
    localparam int L = chain_len(NUM_DESIGNS, NUM_IOS);
    localparam int BW = $clog2(L);
    localparam int IW = $clog2(NUM_IOS);

    scan_state_t state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [8:0] sel_q, sel_d;
    logic [NUM_IOS-1:0] in_q, in_d, shadow_q, shadow_d, out_q, out_d;
    logic ready_q, ready_d, busy_q, busy_d, sclk_q, sclk_d, sdata_q, sdata_d;
    logic ssel_q, ssel_d, slatch_q, slatch_d;
    logic en, last, phase, phase_nxt, slot_start, rise, sample, slot_end;
    logic unused_strobes;

    // Slot counter c drives chain position L-1-c; these decode that position.
    function automatic logic hit(input logic [BW-1:0] b, input logic [8:0] s);
        return (32'(L - 1) - 32'(b)) / 32'(NUM_IOS) == 32'(s);
    endfunction
    function automatic logic [IW-1:0] bit_idx(input logic [BW-1:0] b);
        return IW'((32'(L - 1) - 32'(b)) % 32'(NUM_IOS));
    endfunction

    assign en = state_q != IDLE && state_q != DONE;
    assign unused_strobes = phase ^ rise ^ slot_start;

    scan_clk_phase #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk(clk),
        .reset(reset),
        .en(en),
        .phase(phase),
        .phase_nxt(phase_nxt),
        .slot_start(slot_start),
        .rise(rise),
        .sample(sample),
        .slot_end(slot_end)
    );

    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        sel_d = sel_q;
        in_d = in_q;
        shadow_d = shadow_q;
        out_d = out_q;
        ready_d = 1'b0;
        last = bit_q == BW'(L - 1);
        case (state_q)
            SHIFT_IN: if (slot_end) begin
                bit_d = last ? '0 : bit_q + BW'(1);
                state_d = last ? LATCH : SHIFT_IN;
            end
            LATCH: if (slot_end) state_d = CAPTURE;
            CAPTURE: if (slot_end) state_d = SHIFT_OUT;
            SHIFT_OUT: begin
                if (sample && hit(bit_q, sel_q)) shadow_d[bit_idx(bit_q)] = scan_data_in;
                if (slot_end) begin
                    bit_d = last ? '0 : bit_q + BW'(1);
                    state_d = last ? DONE : SHIFT_OUT;
                end
            end
            DONE: begin
                out_d = shadow_q;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (run && (state_q == IDLE || state_q == DONE)) begin
            state_d = SHIFT_IN;
            sel_d = active_select;
            in_d = inputs;
            bit_d = '0;
            shadow_d = '0;
        end
        // Scan pins are computed from next-cycle state so they leave straight from flops.
        busy_d = state_d != IDLE;
        sclk_d = phase_nxt && state_d != LATCH;
        slatch_d = phase_nxt && state_d == LATCH;
        ssel_d = state_d == CAPTURE;
        sdata_d = state_d == SHIFT_IN && hit(bit_d, sel_d) && in_d[bit_idx(bit_d)];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q <= '0;
            sel_q <= '0;
            in_q <= '0;
            shadow_q <= '0;
            out_q <= '0;
            ready_q <= 1'b0;
            busy_q <= 1'b0;
            sclk_q <= 1'b0;
            sdata_q <= 1'b0;
            ssel_q <= 1'b0;
            slatch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            sel_q <= sel_d;
            in_q <= in_d;
            shadow_q <= shadow_d;
            out_q <= out_d;
            ready_q <= ready_d;
            busy_q <= busy_d;
            sclk_q <= sclk_d;
            sdata_q <= sdata_d;
            ssel_q <= ssel_d;
            slatch_q <= slatch_d;
        end
    end

    assign outputs = out_q;
    assign ready = ready_q;
    assign busy = busy_q;
    assign scan_clk_out = sclk_q;
    assign scan_data_out = sdata_q;
    assign scan_select = ssel_q;
    assign scan_latch_en = slatch_q;
endmodule

// File: tb/tb_scan_frame_sequencer.sv
// tb_scan_frame_sequencer: four XOR-A5 cells on the chain, two sequencers (CLK_DIV 1 and 3), random frames vs a frame-level model.
module tb_scan_frame_sequencer;
    localparam int ND = 4;
    localparam int NI = 8;
    localparam int L = ND * NI;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] run = '0;
    logic [8:0] sel = '0;
    logic [7:0] din = '0;
    logic [1:0] rdy, bsy, sclk, sdo, ssel, slat, sdi;
    logic [7:0] outs [2];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : chain_g
        localparam int D = g == 0 ? 1 : 3;
        logic [L-1:0] chain = '0;
        logic dout = 1'b0;
        logic prev = 1'b0;
        logic [7:0] cell_in [ND] = '{default: 8'h00};
        int rises = 0;
        int hi_cnt = 0;
        int hi_min = 1000;
        int hi_max = 0;

        scan_frame_sequencer #(.NUM_DESIGNS(ND), .NUM_IOS(NI), .CLK_DIV(D)) dut (
            .clk(clk),
            .reset(rst),
            .run(run[g]),
            .active_select(sel),
            .inputs(din),
            .outputs(outs[g]),
            .ready(rdy[g]),
            .busy(bsy[g]),
            .scan_clk_out(sclk[g]),
            .scan_data_out(sdo[g]),
            .scan_select(ssel[g]),
            .scan_latch_en(slat[g]),
            .scan_data_in(sdi[g])
        );

        assign sdi[g] = dout;

        // Chain cells shift/capture on scan-clock rise; the last cell re-times its output on the fall.
        always @(negedge clk) begin
            if (sclk[g]) hi_cnt <= hi_cnt + 1;
            if (sclk[g] && !prev) begin
                rises <= rises + 1;
                if (ssel[g]) begin
                    for (int d = 0; d < ND; d++) chain[d*NI +: NI] <= cell_in[d] ^ 8'hA5;
                end else begin
                    chain <= {chain[L-2:0], sdo[g]};
                end
            end
            if (!sclk[g] && prev) begin
                dout <= chain[L-1];
                hi_min <= hi_cnt < hi_min ? hi_cnt : hi_min;
                hi_max <= hi_cnt > hi_max ? hi_cnt : hi_max;
                hi_cnt <= 0;
            end
            if (slat[g]) begin
                for (int d = 0; d < ND; d++) cell_in[d] <= chain[d*NI +: NI];
            end
            prev <= sclk[g];
        end
    end

    function automatic int frame_len(input int d);
        return (2 * L + 2) * 2 * d + 1;
    endfunction

    function automatic logic [7:0] exp_out(input logic [8:0] s, input logic [7:0] x);
        return s < ND ? x ^ 8'hA5 : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic start_frame(input int g, input logic [8:0] s, input logic [7:0] x);
        sel = s;
        din = x;
        run[g] = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ready(input int g, output int lat);
        lat = 0;
        while (!rdy[g] && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        check("ready_seen", 32'(rdy[g]), 1);
    endtask

    task automatic check_cells(input logic [8:0] s, input logic [7:0] x);
        for (int d = 0; d < ND; d++)
            check($sformatf("cell_in%0d", d), 32'(chain_g[0].cell_in[d]), 32'(d == int'(s) ? x : 8'h00));
    endtask

    task automatic idle_window(input int n, input string tag);
        int pulses = 0;
        int busy_seen = 0;
        repeat (n) begin
            @(negedge clk);
            pulses += int'(rdy[0]);
            busy_seen += int'(bsy[0]);
        end
        check({tag, "_ready_pulses"}, pulses, 0);
        check({tag, "_busy"}, busy_seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0;
        logic [8:0] s;
        logic [7:0] x;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", 32'(outs[0]), 0);
        check("rst_ready", 32'(rdy[0]), 0);
        check("rst_busy", 32'(bsy[0]), 0);
        check("rst_scan", 32'({sclk[0], sdo[0], ssel[0], slat[0]}), 0);

        // Single frame, run dropped one cycle after the frame starts.
        start_frame(0, 9'd2, 8'h3C);
        check("a_busy", 32'(bsy[0]), 1);
        run[0] = 1'b0;
        wait_ready(0, lat);
        check("a_latency", lat, frame_len(1));
        check("a_outputs", 32'(outs[0]), 32'(exp_out(9'd2, 8'h3C)));
        check_cells(9'd2, 8'h3C);
        idle_window(30, "a_idle");

        // Same stimulus on the CLK_DIV=3 instance.
        r0 = chain_g[1].rises;
        start_frame(1, 9'd2, 8'h3C);
        run[1] = 1'b0;
        wait_ready(1, lat);
        check("b_latency", lat, frame_len(3));
        check("b_outputs", 32'(outs[1]), 32'(exp_out(9'd2, 8'h3C)));
        check("b_rises", chain_g[1].rises - r0, 2 * L + 1);
        check("b_high_min", chain_g[1].hi_min, 3);
        check("b_high_max", chain_g[1].hi_max, 3);

        // Back-to-back frames with the input byte changed mid-frame.
        start_frame(0, 9'd2, 8'h3C);
        repeat (60) @(negedge clk);
        din = 8'hFF;
        wait_ready(0, lat);
        check("c_frame1_outputs", 32'(outs[0]), 32'(exp_out(9'd2, 8'h3C)));
        check("c_no_gap_busy", 32'(bsy[0]), 1);
        run[0] = 1'b0;
        @(negedge clk);
        wait_ready(0, lat);
        check("c_frame_period", lat + 1, frame_len(1));
        check("c_frame2_outputs", 32'(outs[0]), 32'(exp_out(9'd2, 8'hFF)));

        // Out-of-range select.
        start_frame(0, 9'd7, 8'hC3);
        run[0] = 1'b0;
        wait_ready(0, lat);
        check("d_outputs", 32'(outs[0]), 0);
        check_cells(9'd7, 8'hC3);

        start_frame(0, 9'd1, 8'h81);
        run[0] = 1'b0;
        wait_ready(0, lat);
        check("e_outputs", 32'(outs[0]), 32'(exp_out(9'd1, 8'h81)));

        // Reset in the middle of a frame.
        start_frame(0, 9'd3, 8'h5E);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("f_busy", 32'(bsy[0]), 0);
        check("f_scan", 32'({sclk[0], sdo[0], ssel[0], slat[0]}), 0);
        check("f_outputs", 32'(outs[0]), 0);
        check("f_ready", 32'(rdy[0]), 0);
        run[0] = 1'b0;
        rst = 1'b0;
        idle_window(150, "f_idle");

        // Random frames against the cell-level model.
        for (int i = 0; i < 10; i++) begin
            s = 9'($urandom_range(0, 7));
            x = 8'($urandom);
            start_frame(0, s, x);
            run[0] = 1'b0;
            wait_ready(0, lat);
            check($sformatf("r%0d_latency", i), lat, frame_len(1));
            check($sformatf("r%0d_outputs", i), 32'(outs[0]), 32'(exp_out(s, x)));
            check_cells(s, x);
            @(negedge clk);
        end
        check("g_high_min", chain_g[0].hi_min, 1);
        check("g_high_max", chain_g[0].hi_max, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
